// File: rtl/tl_sensor_cond_if.sv
// Detector-side bus of the sensor conditioner: raw loop inputs, fault clear,
// conditioned traffic-present outputs and sticky fault flags.
interface tl_sensor_cond_if;
    logic       sens_a;
    logic       sens_b;
    logic       sens_al;
    logic       sens_bl;
    logic       clr_fault;
    logic       Ta;
    logic       Tb;
    logic       Tal;
    logic       Tbl;
    logic [3:0] fault;

    modport master (
        output sens_a, sens_b, sens_al, sens_bl, clr_fault,
        input  Ta, Tb, Tal, Tbl, fault
    );

    modport slave (
        input  sens_a, sens_b, sens_al, sens_bl, clr_fault,
        output Ta, Tb, Tal, Tbl, fault
    );
endinterface

// File: rtl/tl_sensor_cond.sv
// Four identical loop-detector channels: 2-flop sync, debounce, gap-out hold,
// stuck-sensor detection with fail-safe forcing of the traffic-present output.
module tl_sensor_cond #(
    parameter int DEB_CYC   = 4,
    parameter int HOLD_CYC  = 3,
    parameter int STUCK_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    tl_sensor_cond_if.slave  bus
);

    localparam logic [7:0] DEB_LAST   = 8'(DEB_CYC - 1);
    localparam logic [7:0] HOLD_INIT  = 8'(HOLD_CYC);
    localparam logic [7:0] STUCK_MAX  = 8'(STUCK_CYC);
    localparam logic [7:0] STUCK_LAST = 8'(STUCK_CYC - 1);

    logic [3:0] sens_vec;
    logic [3:0] t_vec;
    logic [3:0] flt_vec;

    assign sens_vec = {bus.sens_bl, bus.sens_al, bus.sens_b, bus.sens_a};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic       sync1_q, sync2_q;
            logic       deb_q, deb_d;
            logic [7:0] cnt_q, cnt_d;
            logic [7:0] hold_q, hold_d;
            logic [7:0] stuck_q, stuck_d;
            logic       flt_q, flt_d;
            logic       t_q, t_d;

            always_comb begin
                deb_d = deb_q;
                cnt_d = cnt_q;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    deb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end

                // Hold reloads on the falling debounce edge and is dropped on re-arrival.
                hold_d = hold_q;
                if (deb_q && !deb_d) begin
                    hold_d = HOLD_INIT;
                end else if (!deb_q && deb_d) begin
                    hold_d = '0;
                end else if (!deb_q && (hold_q != '0)) begin
                    hold_d = hold_q - 8'd1;
                end

                stuck_d = stuck_q;
                if (bus.clr_fault) begin
                    stuck_d = '0;
                end else if (deb_q) begin
                    stuck_d = (stuck_q == STUCK_MAX) ? stuck_q : stuck_q + 8'd1;
                end else begin
                    stuck_d = '0;
                end

                // Setting beats clearing so a simultaneous clear cannot hide a stuck loop.
                flt_d = flt_q;
                if (deb_q && (stuck_q == STUCK_LAST)) begin
                    flt_d = 1'b1;
                end else if (bus.clr_fault) begin
                    flt_d = 1'b0;
                end

                t_d = deb_q | (hold_q != '0) | flt_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                    hold_q  <= '0;
                    stuck_q <= '0;
                    flt_q   <= 1'b0;
                    t_q     <= 1'b0;
                end else begin
                    sync1_q <= sens_vec[gi];
                    sync2_q <= sync1_q;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                    hold_q  <= hold_d;
                    stuck_q <= stuck_d;
                    flt_q   <= flt_d;
                    t_q     <= t_d;
                end
            end

            assign t_vec[gi]   = t_q;
            assign flt_vec[gi] = flt_q;
        end
    endgenerate

    assign bus.Ta    = t_vec[0];
    assign bus.Tb    = t_vec[1];
    assign bus.Tal   = t_vec[2];
    assign bus.Tbl   = t_vec[3];
    assign bus.fault = flt_vec;

endmodule
